cla_serial_ctrl: RTL and testbench
==================================

CLA_SERIAL_CTRL -- requirements
Module: cla_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, minimum 8; N = WIDTH/4 nibbles.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an add request pending.
REQ-005 req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions/widths/meanings as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result this cycle when high with rsp_valid.
REQ-011 rsp_sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-012 rsp_cout  output  1  carry out of bit WIDTH-1.
REQ-013 rsp_id  output  1  index of requester that issued the result.
REQ-014 busy  output  1  high in ADD and DONE states.

Function
REQ-015 Block SHALL contain exactly one instance of the team's 4-bit carry-lookahead adder, time-shared across nibbles and requesters; no other adder logic on the sum path.
REQ-016 FSM states: IDLE, ADD, DONE; reset state IDLE.
REQ-017 IDLE: grant computed combinationally from valids and round-robin pointer; only the granted requester's ready SHALL be high; both readys low when no valid.
REQ-018 Round-robin: pointer favors req0 after reset; after any accept, pointer favors the other requester; a lone valid requester is always granted regardless of pointer.
REQ-019 Accept (ready & valid in IDLE): capture a, b, cin, id; nibble counter to 0; next state ADD.
REQ-020 ADD: each cycle apply nibble k of captured a/b and carry register to CLA; store 4-bit sum into bits [4k+3:4k] of result register; carry register <= CLA carry-out; k increments.
REQ-021 ADD lasts exactly N cycles; after nibble N-1, next state DONE, rsp_cout = final carry.
REQ-022 Latency: if accept occurs in cycle 0, rsp_valid SHALL first be high in cycle N+1 (cycle 5 for WIDTH=16).
REQ-023 DONE: rsp_valid high; rsp_sum, rsp_cout, rsp_id held stable until rsp_ready; on rsp_valid & rsp_ready next state IDLE.
REQ-024 req0_ready and req1_ready SHALL be low in ADD and DONE; new input changes there have no effect.
REQ-025 rsp_valid low in IDLE and ADD; rsp_sum/rsp_cout/rsp_id values outside DONE are don't-care but SHALL not change in DONE.
REQ-026 Minimum issue interval per accepted request: N+2 cycles with rsp_ready held high.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, busy 0, both readys 0, result/carry/counter/rsp_id 0, pointer favoring req0.
REQ-028 Reset asserted in ADD or DONE SHALL abort the operation with no response ever issued for it.
REQ-029 After rst_n deasserts, first accept may occur on the first rising edge with a valid.

Verification
REQ-030 req0 a=0x1234 b=0x0FCD cin=0, rsp_ready=1 -> rsp_sum=0x2201, rsp_cout=0, rsp_id=0, rsp_valid exactly 5 cycles after accept cycle.
REQ-031 req0 a=0xFFFF b=0x0000 cin=1 -> rsp_sum=0x0000, rsp_cout=1 (carry ripples through all 4 nibbles).
REQ-032 After reset, req0 and req1 valid together and held for 3 requests each -> grants in order 0,1,0,1,0,1; rsp_id follows.
REQ-033 req1 alone a=0x8000 b=0x8000 cin=0 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
REQ-034 rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_sum, rsp_cout stable, both readys 0, busy 1; IDLE the cycle after rsp_ready rises.
REQ-035 rst_n pulsed low during ADD cycle 2 -> rsp_valid never asserts for that request; after release with both valids high, req0 granted first.

Source files
------------

// File: rtl/cla_serial_ctrl.sv
// cla_serial_ctrl: two-requester serial adder built around one 4-bit CLA.
// Operands are added one nibble per cycle; a round-robin arbiter picks the
// requester, and the result is held on a valid/ready response port.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req0_valid/ready/a/b/cin    requester 0 handshake and operands
//   req1_valid/ready/a/b/cin    requester 1 handshake and operands
//   rsp_valid/ready             response handshake
//   rsp_sum/cout/id             a+b+cin, carry out, issuing requester
//   busy                        high while adding or holding a result
//
// cla4: 4-bit carry-lookahead adder, the only adder on the sum path.
//   i_a, i_b, i_c -> o_s (sum nibble), o_c (carry out)

module cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_s = w_p ^ w_c[3:0];
    assign o_c = w_c[4];
endmodule

module cla_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_id;
    logic [CW-1:0]    r_cnt;

    logic             w_g0;
    logic             w_g1;
    logic             w_acc;
    logic             w_last;
    logic [3:0]       w_na;
    logic [3:0]       w_nb;
    logic [3:0]       w_ns;
    logic             w_nc;

    // r_ptr=0 favours req0; a lone valid wins regardless of the pointer.
    assign w_g0 = req0_valid & (~req1_valid | ~r_ptr);
    assign w_g1 = req1_valid & (~req0_valid | r_ptr);

    assign w_na   = r_a[{r_cnt, 2'b00} +: 4];
    assign w_nb   = r_b[{r_cnt, 2'b00} +: 4];
    assign w_last = (r_cnt == CW'(N - 1));

    cla4 u_cla (
        .i_a (w_na),
        .i_b (w_nb),
        .i_c (r_carry),
        .o_s (w_ns),
        .o_c (w_nc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Readys are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        w_acc      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = rst_n & w_g0;
                req1_ready = rst_n & w_g1;
                w_acc      = rst_n & (w_g0 | w_g1);
                if (w_acc) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_acc) begin
            r_a     <= w_g1 ? req1_a : req0_a;
            r_b     <= w_g1 ? req1_b : req0_b;
            r_carry <= w_g1 ? req1_cin : req0_cin;
            r_id    <= w_g1;
            r_cnt   <= '0;
            // Next contention goes to whoever was not just served.
            r_ptr   <= w_g0;
        end else if (r_state == S_ADD) begin
            r_sum[{r_cnt, 2'b00} +: 4] <= w_ns;
            r_carry <= w_nc;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // In DONE the carry register holds the carry out of the top nibble.
    assign rsp_sum  = r_sum;
    assign rsp_cout = r_carry;
    assign rsp_id   = r_id;
endmodule

// File: tb/tb_cla_serial_ctrl.sv
// Self-checking bench for cla_serial_ctrl (WIDTH=16).
// Reference model: plain integer addition plus a last-served arbiter model.

module tb_cla_serial_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
    logic [W-1:0] rsp_sum;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 1;

    cla_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model arbiter: both valid -> the one not served last; else the lone one.
    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) return (m_last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic rand_ops(input int idx);
        if (idx == 0) begin
            req0_a   = W'($urandom);
            req0_b   = W'($urandom);
            req0_cin = 1'($urandom);
        end else begin
            req1_a   = W'($urandom);
            req1_b   = W'($urandom);
            req1_cin = 1'($urandom);
        end
    endtask

    // Waits for a grant, lets it complete, checks the response.
    // Called at a negedge; returns at negedge+1 of the first DONE cycle.
    task automatic serve(input logic keep);
        int       lat;
        int       g;
        int       eg;
        logic     bad;
        logic [W:0] exp;
        lat = 0;
        #1;
        while (!(req0_ready || req1_ready) && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("ready_wait", 32'(lat < 20), 32'd1);
        check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        g  = req1_ready ? 1 : 0;
        eg = model_grant(req0_valid, req1_valid);
        check("grant", g, eg);
        if (g == 1)
            exp = {1'b0, req1_a} + (W+1)'(req1_b) + (W+1)'(req1_cin);
        else
            exp = {1'b0, req0_a} + (W+1)'(req0_b) + (W+1)'(req0_cin);
        m_last = g;
        @(posedge clk);
        bad = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                if (!keep) begin
                    if (g == 0) req0_valid = 1'b0;
                    else req1_valid = 1'b0;
                end
                rand_ops(g);
            end
            if (!rsp_valid && (req0_ready || req1_ready || !busy))
                bad = 1'b1;
        end while (!rsp_valid && lat < 40);
        check("latency", lat, N + 1);
        check("add_phase", 32'(bad), 32'd0);
        check("sum", 32'(rsp_sum), 32'(exp[W-1:0]));
        check("cout", 32'(rsp_cout), 32'(exp[W]));
        check("id", 32'(rsp_id), g);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc;
        logic         bad;

        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rand_ops(0);
        rand_ops(1);
        #2;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        m_last = 1;

        // Directed: mixed carries, full ripple, req1 alone.
        @(negedge clk);
        req0_a = 16'h1234; req0_b = 16'h0FCD; req0_cin = 1'b0;
        req0_valid = 1'b1;
        serve(1'b0);
        check("d1_sum", 32'(rsp_sum), 32'h2201);
        check("d1_cout", 32'(rsp_cout), 32'd0);

        @(negedge clk);
        req0_a = 16'hFFFF; req0_b = 16'h0000; req0_cin = 1'b1;
        req0_valid = 1'b1;
        serve(1'b0);
        check("d2_sum", 32'(rsp_sum), 32'h0000);
        check("d2_cout", 32'(rsp_cout), 32'd1);

        @(negedge clk);
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
        req1_valid = 1'b1;
        serve(1'b0);
        check("d3_sum", 32'(rsp_sum), 32'h0000);
        check("d3_cout", 32'(rsp_cout), 32'd1);
        check("d3_id", 32'(rsp_id), 32'd1);

        // Fresh reset, then both requesters held valid: strict alternation.
        @(negedge clk);
        rst_n = 1'b0;
        m_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        rand_ops(0);
        rand_ops(1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serve(1'b1);
            check("rr_order", 32'(rsp_id), 32'(i % 2));
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int v;
            @(negedge clk);
            v = $urandom_range(1, 3);
            req0_valid = v[0];
            req1_valid = v[1];
            rand_ops(0);
            rand_ops(1);
            serve(1'b0);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure: result and handshake outputs frozen while stalled.
        @(negedge clk);
        rand_ops(0);
        req0_valid = 1'b1;
        rsp_ready  = 1'b0;
        serve(1'b0);
        hs  = rsp_sum;
        hc  = rsp_cout;
        bad = 1'b0;
        req1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            rand_ops(1);
            if (!rsp_valid || rsp_sum !== hs || rsp_cout !== hc ||
                rsp_id !== 1'b0 || req0_ready || req1_ready || !busy)
                bad = 1'b1;
        end
        check("stall_hold", 32'(bad), 32'd0);
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        #1;
        check("stall_exit_busy", 32'(busy), 32'd0);
        check("stall_exit_valid", 32'(rsp_valid), 32'd0);

        // Reset in the middle of ADD aborts the operation.
        rand_ops(0);
        req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_busy_add", 32'(busy), 32'd1);
        req1_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        m_last = 1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_readys", 32'(req0_ready | req1_ready), 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (rsp_valid || busy) bad = 1'b1;
        end
        check("abort_no_rsp", 32'(bad), 32'd0);
        rand_ops(0);
        rand_ops(1);
        rst_n = 1'b1;
        serve(1'b0);
        check("abort_first_id", 32'(rsp_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
